// File: rtl/flappy_defs_pkg.sv
// flappy_defs: game-state encodings and pipe geometry shared by the scheduler,
// the collision checker and the renderer so the obstacle shape is defined once.
package flappy_defs;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FROZEN = 2'd2
    } state_t;

    localparam logic [9:0] SCREEN_W   = 10'd640;
    localparam logic [9:0] PIPE_WIDTH = 10'd80;
    localparam logic [9:0] GAP_HEIGHT = 10'd100;
    localparam logic [9:0] GAP_MIN    = 10'd40;
    localparam logic [9:0] GAP_MAX    = 10'd340;

    // Two-digit BCD increment; 99 wraps to 00.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        logic [3:0] u, t;
        u = (v[3:0] == 4'd9) ? 4'd0 : v[3:0] + 4'd1;
        t = (v[3:0] != 4'd9) ? v[7:4] : ((v[7:4] == 4'd9) ? 4'd0 : v[7:4] + 4'd1);
        return {t, u};
    endfunction

endpackage

// File: rtl/pipe_scheduler_gap_lfsr.sv
// gap_lfsr: free-running 10-bit Fibonacci LFSR (x^10+x^7+1) folded into
// the legal gap-top range for a freshly recycled pipe.
module gap_lfsr #(
    parameter logic [9:0] LFSR_SEED = 10'h2A5,
    parameter logic [9:0] GAP_MIN   = flappy_defs::GAP_MIN,
    parameter logic [9:0] GAP_MAX   = flappy_defs::GAP_MAX
) (
    input  logic       Clk,
    input  logic       reset,
    output logic [9:0] Gap_o
);
    logic [9:0] lfsr_q, lfsr_d, t;

    assign lfsr_d = {lfsr_q[8:0], lfsr_q[9] ^ lfsr_q[6]};

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) lfsr_q <= LFSR_SEED;
        else       lfsr_q <= lfsr_d;
    end

    assign t     = GAP_MIN + {2'b0, lfsr_q[7:0]};
    assign Gap_o = (t > GAP_MAX) ? t - 10'd128 : t;

endmodule

// File: rtl/pipe_scheduler.sv
// pipe_scheduler: scrolls and recycles the pipe set, tracks the pipe facing
// the bird for collision checks, and keeps the BCD score.
module pipe_scheduler #(
    parameter int          NUM_PIPES    = 3,
    parameter logic [9:0]  PIPE_SPACING = 10'd240,
    parameter logic [9:0]  PIPE_WIDTH   = flappy_defs::PIPE_WIDTH,
    parameter logic [9:0]  SCREEN_W     = flappy_defs::SCREEN_W,
    parameter logic [19:0] SCROLL_DIV   = 20'd250000,
    parameter logic [9:0]  GAP_MIN      = flappy_defs::GAP_MIN,
    parameter logic [9:0]  GAP_MAX      = flappy_defs::GAP_MAX,
    parameter logic [9:0]  GAP_INIT     = 10'd200,
    parameter logic [9:0]  LFSR_SEED    = 10'h2A5
) (
    input  logic       Clk,
    input  logic       reset,
    input  logic       Start_i,
    input  logic       Lose_i,
    input  logic       Ack_i,
    input  logic [9:0] Bird_X_i,
    input  logic [1:0] Rd_Sel_i,
    output logic [9:0] X_Edge_o,
    output logic [9:0] Y_Edge_o,
    output logic [9:0] Rd_X_o,
    output logic [9:0] Rd_Y_o,
    output logic [7:0] Score_o,
    output logic       Scroll_Tick_o,
    output logic       Q_Idle_o,
    output logic       Q_Run_o,
    output logic       Q_Frozen_o
);
    import flappy_defs::*;

    // A pipe leaving at x=0 reappears one full rotation to the right.
    localparam logic [9:0] WRAP_X = 10'(NUM_PIPES * PIPE_SPACING - 1);

    function automatic logic [9:0] init_x(input int i);
        return 10'(SCREEN_W + i * PIPE_SPACING);
    endfunction

    state_t      state_q, state_d;
    logic [9:0]  px_q [NUM_PIPES];
    logic [9:0]  px_d [NUM_PIPES];
    logic [9:0]  py_q [NUM_PIPES];
    logic [9:0]  py_d [NUM_PIPES];
    logic [1:0]  cur_q, cur_d;
    logic [7:0]  score_q, score_d;
    logic [19:0] div_q, div_d;
    logic [9:0]  xe_q, ye_q, cur_x, cur_y, gap;
    logic        run, tick, pass;

    gap_lfsr #(
        .LFSR_SEED(LFSR_SEED),
        .GAP_MIN  (GAP_MIN),
        .GAP_MAX  (GAP_MAX)
    ) u_gap (
        .Clk  (Clk),
        .reset(reset),
        .Gap_o(gap)
    );

    always_comb begin
        cur_x  = px_q[0];
        cur_y  = py_q[0];
        Rd_X_o = 10'h3FF;
        Rd_Y_o = '0;
        for (int i = 1; i < NUM_PIPES; i++)
            if (cur_q == 2'(i)) begin
                cur_x = px_q[i];
                cur_y = py_q[i];
            end
        for (int i = 0; i < NUM_PIPES; i++)
            if (Rd_Sel_i == 2'(i)) begin
                Rd_X_o = px_q[i];
                Rd_Y_o = py_q[i];
            end
    end

    // Lose masks every RUN-state event in the cycle it is seen.
    assign run  = (state_q == ST_RUN) && !Lose_i;
    assign tick = run && (div_q == SCROLL_DIV - 20'd1);
    assign pass = run && (cur_x + PIPE_WIDTH < Bird_X_i);

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        score_d = score_q;
        div_d   = div_q;
        px_d    = px_q;
        py_d    = py_q;
        case (state_q)
            ST_IDLE: if (Start_i) begin
                state_d = ST_RUN;
                cur_d   = '0;
                score_d = '0;
                div_d   = '0;
                for (int i = 0; i < NUM_PIPES; i++) begin
                    px_d[i] = init_x(i);
                    py_d[i] = GAP_INIT;
                end
            end
            ST_RUN: if (Lose_i) begin
                state_d = ST_FROZEN;
            end else begin
                div_d = tick ? '0 : div_q + 20'd1;
                if (tick)
                    for (int i = 0; i < NUM_PIPES; i++) begin
                        px_d[i] = (px_q[i] == '0) ? WRAP_X : px_q[i] - 10'd1;
                        py_d[i] = (px_q[i] == '0) ? gap : py_q[i];
                    end
                if (pass) begin
                    score_d = bcd_inc(score_q);
                    cur_d   = (cur_q == 2'(NUM_PIPES - 1)) ? 2'd0 : cur_q + 2'd1;
                end
            end
            ST_FROZEN: if (Ack_i) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cur_q   <= '0;
            score_q <= '0;
            div_q   <= '0;
            xe_q    <= SCREEN_W;
            ye_q    <= GAP_INIT;
            for (int i = 0; i < NUM_PIPES; i++) begin
                px_q[i] <= init_x(i);
                py_q[i] <= GAP_INIT;
            end
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            score_q <= score_d;
            div_q   <= div_d;
            xe_q    <= cur_x;
            ye_q    <= cur_y;
            px_q    <= px_d;
            py_q    <= py_d;
        end
    end

    assign X_Edge_o      = xe_q;
    assign Y_Edge_o      = ye_q;
    assign Score_o       = score_q;
    assign Scroll_Tick_o = tick;
    assign Q_Idle_o      = state_q == ST_IDLE;
    assign Q_Run_o       = state_q == ST_RUN;
    assign Q_Frozen_o    = state_q == ST_FROZEN;

endmodule

// File: tb/tb_pipe_scheduler.sv
// tb_pipe_scheduler: directed stimulus with a score scoreboard; a second small
// instance runs the score through 99 -> 00 quickly.
module tb_pipe_scheduler;

    logic       Clk = 1'b0, reset = 1'b0;
    logic       Start = 1'b0, Lose = 1'b0, Ack = 1'b0, Start2 = 1'b0;
    logic [9:0] Bird_X = 10'd200, Bird_X2 = 10'd3;
    logic [1:0] Rd_Sel = 2'd0, Rd_Sel2 = 2'd0;
    logic [9:0] X_Edge, Y_Edge, Rd_X, Rd_Y, X_Edge2, Y_Edge2, Rd_X2, Rd_Y2;
    logic [7:0] Score, Score2;
    logic       Scroll_Tick, Q_Idle, Q_Run, Q_Frozen, Tick2, Idle2, Run2, Frozen2;

    int tests = 0, fails = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp2_q[$];
    logic [7:0] prev = 8'h00, prev2 = 8'h00;

    always #5 Clk = ~Clk;

    pipe_scheduler #(.SCROLL_DIV(20'd4)) dut (
        .Clk(Clk), .reset(reset), .Start_i(Start), .Lose_i(Lose), .Ack_i(Ack),
        .Bird_X_i(Bird_X), .Rd_Sel_i(Rd_Sel), .X_Edge_o(X_Edge), .Y_Edge_o(Y_Edge),
        .Rd_X_o(Rd_X), .Rd_Y_o(Rd_Y), .Score_o(Score), .Scroll_Tick_o(Scroll_Tick),
        .Q_Idle_o(Q_Idle), .Q_Run_o(Q_Run), .Q_Frozen_o(Q_Frozen)
    );

    pipe_scheduler #(
        .NUM_PIPES(2), .PIPE_SPACING(10'd2), .PIPE_WIDTH(10'd1),
        .SCREEN_W(10'd4), .SCROLL_DIV(20'd2)
    ) dut2 (
        .Clk(Clk), .reset(reset), .Start_i(Start2), .Lose_i(1'b0), .Ack_i(1'b0),
        .Bird_X_i(Bird_X2), .Rd_Sel_i(Rd_Sel2), .X_Edge_o(X_Edge2), .Y_Edge_o(Y_Edge2),
        .Rd_X_o(Rd_X2), .Rd_Y_o(Rd_Y2), .Score_o(Score2), .Scroll_Tick_o(Tick2),
        .Q_Idle_o(Idle2), .Q_Run_o(Run2), .Q_Frozen_o(Frozen2)
    );

    task automatic chk(input string n, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", n, act, exp);
        end
    endtask

    always @(negedge Clk) begin
        logic [7:0] e;
        if (Score != prev) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL score: got %h, no change expected", Score);
            end else begin
                e = exp_q.pop_front();
                if (Score != e) begin
                    fails++;
                    $display("FAIL score: got %h, expected %h", Score, e);
                end
            end
            prev = Score;
        end
        if (Score2 != prev2) begin
            tests++;
            if (exp2_q.size() == 0) begin
                fails++;
                $display("FAIL score2: got %h, no change expected", Score2);
            end else begin
                e = exp2_q.pop_front();
                if (Score2 != e) begin
                    fails++;
                    $display("FAIL score2: got %h, expected %h", Score2, e);
                end
            end
            prev2 = Score2;
        end
    end

    initial begin
        int n;
        logic [9:0] a1, a2, xb;
        #1 reset = 1'b1;
        @(negedge Clk);
        chk("rst_idle", Q_Idle, 1);
        chk("rst_score", Score, 0);
        chk("rst_xedge", X_Edge, 640);
        chk("rst_yedge", Y_Edge, 200);
        chk("rst_tick", Scroll_Tick, 0);
        Rd_Sel = 2'd1; #1;
        chk("rst_rdx1", Rd_X, 880);
        Rd_Sel = 2'd3; #1;
        chk("rdx_oob", Rd_X, 10'h3FF);
        chk("rdy_oob", Rd_Y, 0);
        Rd_Sel = 2'd0;
        @(negedge Clk);
        reset = 1'b0;

        exp_q.push_back(8'h01);
        @(negedge Clk); Start = 1'b1;
        @(negedge Clk); Start = 1'b0;
        chk("start_run", Q_Run, 1);
        chk("tick_c1", Scroll_Tick, 0);
        @(negedge Clk); chk("tick_c2", Scroll_Tick, 0);
        @(negedge Clk); chk("tick_c3", Scroll_Tick, 0);
        @(negedge Clk); chk("tick_c4", Scroll_Tick, 1);
        chk("xedge_pre", X_Edge, 640);
        @(negedge Clk); chk("rdx0_step", Rd_X, 639);
        chk("xedge_lat", X_Edge, 640);
        @(negedge Clk); chk("xedge_step", X_Edge, 639);
        @(negedge Clk); chk("tick_c7", Scroll_Tick, 0);
        @(negedge Clk); chk("tick_c8", Scroll_Tick, 1);
        @(negedge Clk); Start = 1'b1; Ack = 1'b1;
        @(negedge Clk); Start = 1'b0; Ack = 1'b0;
        chk("start_ign_run", Q_Run, 1);
        chk("start_ign_x", Rd_X, 638);

        n = 0;
        while (Score != 8'h01 && n < 3000) begin @(negedge Clk); n++; end
        chk("pass_seen", int'(n < 3000), 1);
        chk("xedge_old_cur", X_Edge, 119);
        @(negedge Clk);
        chk("xedge_new_cur", X_Edge, 359);

        n = 0;
        while (Rd_X != 10'd0 && n < 1000) begin @(negedge Clk); n++; end
        chk("x0_zero_seen", int'(n < 1000), 1);
        Rd_Sel = 2'd1; #1 a1 = Rd_X;
        Rd_Sel = 2'd2; #1 a2 = Rd_X;
        Rd_Sel = 2'd0; #1;
        chk("x1_at_zero", a1, 240);
        n = 0;
        while (!Scroll_Tick && n < 10) begin @(negedge Clk); n++; end
        chk("wrap_tick_seen", int'(n < 10), 1);
        @(negedge Clk);
        chk("wrap_x0", Rd_X, 719);
        chk("wrap_y0_range", int'(Rd_Y >= 10'd40 && Rd_Y <= 10'd340), 1);
        Rd_Sel = 2'd1; #1 chk("wrap_x1_dec", Rd_X, a1 - 10'd1);
        Rd_Sel = 2'd2; #1 chk("wrap_x2_dec", Rd_X, a2 - 10'd1);
        Rd_Sel = 2'd0; #1;

        n = 0;
        while (!Scroll_Tick && n < 10) begin @(negedge Clk); n++; end
        xb = Rd_X;
        Lose = 1'b1; #1;
        chk("lose_tick_mask", Scroll_Tick, 0);
        @(negedge Clk);
        chk("lose_frozen", Q_Frozen, 1);
        chk("lose_no_dec", Rd_X, xb);
        repeat (8) @(negedge Clk);
        chk("frozen_x_hold", Rd_X, xb);
        chk("frozen_score", Score, 8'h01);
        Lose = 1'b0; Start = 1'b1;
        @(negedge Clk); Start = 1'b0;
        chk("start_ign_frozen", Q_Frozen, 1);
        Ack = 1'b1;
        @(negedge Clk); Ack = 1'b0;
        chk("ack_idle", Q_Idle, 1);
        chk("idle_x_visible", Rd_X, xb);
        chk("idle_score_vis", Score, 8'h01);

        exp_q.push_back(8'h00);
        Bird_X = 10'd100; Start = 1'b1;
        @(negedge Clk); Start = 1'b0;
        chk("restart_run", Q_Run, 1);
        chk("restart_x0", Rd_X, 640);
        @(negedge Clk);
        chk("restart_xedge", X_Edge, 640);

        repeat (6) @(negedge Clk);
        #2 reset = 1'b1;
        #1;
        chk("mrst_idle", Q_Idle, 1);
        chk("mrst_run", Q_Run, 0);
        chk("mrst_xedge", X_Edge, 640);
        chk("mrst_yedge", Y_Edge, 200);
        chk("mrst_tick", Scroll_Tick, 0);
        chk("mrst_score", Score, 0);
        chk("mrst_x0", Rd_X, 640);
        @(negedge Clk);
        reset = 1'b0;

        for (int k = 1; k <= 99; k++) exp2_q.push_back({4'(k / 10), 4'(k % 10)});
        exp2_q.push_back(8'h00);
        exp2_q.push_back(8'h01);
        @(negedge Clk); Start2 = 1'b1;
        @(negedge Clk); Start2 = 1'b0;
        n = 0;
        while (exp2_q.size() != 0 && n < 1000) begin @(negedge Clk); n++; end
        chk("score2_wrap_done", int'(n < 1000), 1);
        chk("score2_final", Score2, 8'h01);
        chk("sb_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
